// File: rtl/jt7759_fifo_if.sv
// Bus bundle for the jt7759 data-input stage: control-FSM fetch port, ROM port and host write port.
// The slave modport is the FIFO's own view; master is the view of whatever drives it.
interface jt7759_fifo_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 17
);
    logic          ctrl_cs;
    logic [AW-1:0] ctrl_addr;
    logic [DW-1:0] ctrl_din;
    logic          ctrl_ok;

    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rom_ok;

    logic          cs;
    logic          wrn;
    logic [DW-1:0] din;
    logic          drqn;

    modport slave (
        input  ctrl_cs, ctrl_addr,
        output ctrl_din, ctrl_ok,
        output rom_cs, rom_addr,
        input  rom_data, rom_ok,
        input  cs, wrn, din,
        output drqn
    );

    modport master (
        output ctrl_cs, ctrl_addr,
        input  ctrl_din, ctrl_ok,
        input  rom_cs, rom_addr,
        output rom_data, rom_ok,
        output cs, wrn, din,
        input  drqn
    );
endinterface

// File: rtl/jt7759_fifo.sv
// jt7759 data-input stage: ROM pass-through in master mode, DEPTH-entry host FIFO in slave mode
// with DRQ low-water mark and hold-off, occupancy output and sticky overflow.
module jt7759_fifo #(
    parameter int unsigned DW      = 8,
    parameter int unsigned AW      = 17,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned LOWMARK = 1,
    parameter int unsigned HOLDOFF = 3
) (
    input  logic                         rst,
    input  logic                         clk,
    input  logic                         cen4,
    input  logic                         mdn,
    input  logic                         flush,
    jt7759_fifo_if.slave                 bus,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         ovf
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned HW = $clog2(HOLDOFF + 2);

    typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] rd_ptr_q, wr_ptr_q;
    logic [LW-1:0] level_q, level_d;
    logic [HW-1:0] hold_q;
    logic          ovf_q, last_wrn_q, last_cs_q;
    state_e        state_q, state_d;
    logic          ok_q, ok_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          clear, full, push_req, push, pop, ovf_set;

    // Master mode keeps the FIFO and reader parked so a return to slave mode starts clean.
    assign clear    = flush | mdn;
    assign full     = (level_q == LW'(DEPTH));
    assign push_req = ~mdn & bus.cs & ~bus.wrn & last_wrn_q;
    assign push     = push_req & ~flush & (~full | pop);
    assign ovf_set  = push_req & ~flush & full & ~pop;

    always_comb begin
        state_d = state_q;
        ok_d    = ok_q;
        dout_d  = dout_q;
        pop     = 1'b0;
        if (clear) begin
            state_d = StIdle;
            ok_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: if (bus.ctrl_cs && !last_cs_q) state_d = StWait;
                StWait: begin
                    if (!bus.ctrl_cs) begin
                        state_d = StIdle;
                    end else if (level_q != '0) begin
                        state_d = StAck;
                        ok_d    = 1'b1;
                        dout_d  = mem[rd_ptr_q];
                    end
                end
                StAck: begin
                    if (!bus.ctrl_cs) begin
                        state_d = StIdle;
                        ok_d    = 1'b0;
                        pop     = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        level_d = level_q;
        if (clear) begin
            level_d = '0;
        end else if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    always_ff @(posedge clk, posedge rst) begin
        if (rst) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            level_q    <= '0;
            hold_q     <= '0;
            ovf_q      <= 1'b0;
            last_wrn_q <= 1'b1;
            last_cs_q  <= 1'b0;
            state_q    <= StIdle;
            ok_q       <= 1'b0;
            dout_q     <= '0;
        end else begin
            last_wrn_q <= bus.wrn;
            last_cs_q  <= bus.ctrl_cs;
            state_q    <= state_d;
            ok_q       <= ok_d;
            dout_q     <= dout_d;
            level_q    <= level_d;
            if (clear) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
                if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (flush) begin
                ovf_q <= 1'b0;
            end else if (ovf_set) begin
                ovf_q <= 1'b1;
            end
            if (push) begin
                hold_q <= HW'(HOLDOFF);
            end else if (cen4 && hold_q != '0) begin
                hold_q <= hold_q - HW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= bus.din;
    end

    assign bus.rom_cs   = mdn & bus.ctrl_cs;
    assign bus.rom_addr = bus.ctrl_addr;
    assign bus.ctrl_din = mdn ? bus.rom_data : dout_q;
    assign bus.ctrl_ok  = mdn ? bus.rom_ok : ok_q;
    // A push in the current cycle masks the request so the host cannot race the level update.
    assign bus.drqn     = rst | mdn |
                          ~((level_q <= LW'(LOWMARK)) && (hold_q == '0) && !push);
    assign level        = level_q;
    assign ovf          = ovf_q;

endmodule

// File: tb/tb_jt7759_fifo.sv
// Directed bench for jt7759_fifo: table of combinational port vectors plus hand-written
// sequences for fill/drain, overflow, DRQ hold-off, simultaneous push/pop and mode changes.
module tb_jt7759_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cen4 = 1'b0;
    logic       mdn = 1'b0;
    logic       flush = 1'b0;
    logic [2:0] level;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int ticks = 0;
    bit auto_cen = 1'b0;

    jt7759_fifo_if #(.DW(8), .AW(17)) bus ();

    jt7759_fifo #(
        .DW(8), .AW(17), .DEPTH(4), .LOWMARK(1), .HOLDOFF(3)
    ) dut (
        .rst   (rst),
        .clk   (clk),
        .cen4  (cen4),
        .mdn   (mdn),
        .flush (flush),
        .bus   (bus.slave),
        .level (level),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        mdn;
        logic        ctrl_cs;
        logic [16:0] addr;
        logic [7:0]  rom_data;
        logic        rom_ok;
        logic        exp_rom_cs;
        logic [16:0] exp_rom_addr;
        logic        chk_din;
        logic [7:0]  exp_din;
        logic        exp_ok;
        logic        exp_drqn;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // cen4 is asserted for one clock out of every four while auto_cen is set.
    task automatic step();
        cen4 = auto_cen && (cyc % 4 == 3);
        @(posedge clk);
        #1;
        if (cen4) ticks++;
        cyc++;
    endtask

    task automatic host_write(input logic [7:0] b);
        bus.cs  = 1'b1;
        bus.wrn = 1'b0;
        bus.din = b;
        step();
        bus.cs  = 1'b0;
        bus.wrn = 1'b1;
        step();
    endtask

    task automatic read_byte(input logic [7:0] exp, input string name);
        int n;
        n = 0;
        bus.ctrl_cs = 1'b1;
        step();
        while (!bus.ctrl_ok && n < 20) begin
            step();
            n++;
        end
        check("rd_ok", {31'd0, bus.ctrl_ok}, 32'd1);
        check(name, {24'd0, bus.ctrl_din}, {24'd0, exp});
        bus.ctrl_cs = 1'b0;
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g;
        int t0;
        bus.ctrl_cs   = 1'b0;
        bus.ctrl_addr = '0;
        bus.rom_data  = '0;
        bus.rom_ok    = 1'b0;
        bus.cs        = 1'b0;
        bus.wrn       = 1'b1;
        bus.din       = '0;

        vecs[0] = '{1'b0, 1'b0, 17'h00042, 8'h99, 1'b1, 1'b0, 17'h00042, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 17'h1FFFF, 8'h00, 1'b0, 1'b0, 17'h1FFFF, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 17'h1ABCD, 8'h7E, 1'b1, 1'b1, 17'h1ABCD, 1'b1, 8'h7E, 1'b1, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 17'h00100, 8'hC3, 1'b0, 1'b0, 17'h00100, 1'b1, 8'hC3, 1'b0, 1'b1};
        vecs[4] = '{1'b1, 1'b1, 17'h0F0F0, 8'h5A, 1'b0, 1'b1, 17'h0F0F0, 1'b1, 8'h5A, 1'b0, 1'b1};

        // Reset state
        #12;
        check("rst_level", {29'd0, level}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);
        check("rst_drqn", {31'd0, bus.drqn}, 32'd1);
        check("rst_ctrl_ok", {31'd0, bus.ctrl_ok}, 32'd0);
        rst = 1'b0;
        step();

        // Combinational port table, applied within one clock period
        for (int i = 0; i < 5; i++) begin
            mdn           = vecs[i].mdn;
            bus.ctrl_cs   = vecs[i].ctrl_cs;
            bus.ctrl_addr = vecs[i].addr;
            bus.rom_data  = vecs[i].rom_data;
            bus.rom_ok    = vecs[i].rom_ok;
            #1;
            check("vec_rom_cs", {31'd0, bus.rom_cs}, {31'd0, vecs[i].exp_rom_cs});
            check("vec_rom_addr", {15'd0, bus.rom_addr}, {15'd0, vecs[i].exp_rom_addr});
            if (vecs[i].chk_din)
                check("vec_ctrl_din", {24'd0, bus.ctrl_din}, {24'd0, vecs[i].exp_din});
            check("vec_ctrl_ok", {31'd0, bus.ctrl_ok}, {31'd0, vecs[i].exp_ok});
            check("vec_drqn", {31'd0, bus.drqn}, {31'd0, vecs[i].exp_drqn});
        end
        mdn         = 1'b0;
        bus.ctrl_cs = 1'b0;
        bus.rom_ok  = 1'b0;
        step();
        step();

        // 1: three writes then three reads in order
        host_write(8'h11);
        host_write(8'h22);
        host_write(8'h33);
        check("t1_level3", {29'd0, level}, 32'd3);
        check("t1_ovf", {31'd0, ovf}, 32'd0);
        read_byte(8'h11, "t1_rd0");
        read_byte(8'h22, "t1_rd1");
        read_byte(8'h33, "t1_rd2");
        check("t1_level0", {29'd0, level}, 32'd0);

        // 2: five writes overflow a 4-deep FIFO
        for (int i = 0; i < 5; i++) host_write(8'hA0 + 8'(i));
        check("t2_level4", {29'd0, level}, 32'd4);
        check("t2_ovf_set", {31'd0, ovf}, 32'd1);
        for (int i = 0; i < 4; i++) read_byte(8'hA0 + 8'(i), "t2_rd");
        check("t2_ovf_sticky", {31'd0, ovf}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("t2_ovf_flushed", {31'd0, ovf}, 32'd0);
        flush   = 1'b1;
        bus.cs  = 1'b1;
        bus.wrn = 1'b0;
        bus.din = 8'h77;
        step();
        flush   = 1'b0;
        bus.cs  = 1'b0;
        bus.wrn = 1'b1;
        step();
        check("t2_flush_beats_push", {29'd0, level}, 32'd0);

        // 3: DRQ hold-off and low-water mark
        auto_cen = 1'b1;
        for (int i = 0; i < 20; i++) step();
        check("t3_drqn_idle", {31'd0, bus.drqn}, 32'd0);
        bus.cs  = 1'b1;
        bus.wrn = 1'b0;
        bus.din = 8'h3C;
        #1;
        check("t3_drqn_push_cycle", {31'd0, bus.drqn}, 32'd1);
        step();
        bus.cs  = 1'b0;
        bus.wrn = 1'b1;
        t0 = ticks;
        g  = 0;
        while (bus.drqn && g < 40) begin
            step();
            g++;
        end
        check("t3_holdoff_ticks", ticks - t0, 32'd3);
        check("t3_drqn_low", {31'd0, bus.drqn}, 32'd0);
        check("t3_level1", {29'd0, level}, 32'd1);
        host_write(8'h4D);
        for (int i = 0; i < 20; i++) step();
        check("t3_drqn_above_mark", {31'd0, bus.drqn}, 32'd1);
        check("t3_level2", {29'd0, level}, 32'd2);
        read_byte(8'h3C, "t3_rd0");
        read_byte(8'h4D, "t3_rd1");

        // 4: full FIFO, pop and push in the same clock
        for (int i = 0; i < 4; i++) host_write(8'hB0 + 8'(i));
        check("t4_full", {29'd0, level}, 32'd4);
        bus.ctrl_cs = 1'b1;
        step();
        step();
        check("t4_ack_ok", {31'd0, bus.ctrl_ok}, 32'd1);
        check("t4_head", {24'd0, bus.ctrl_din}, 32'hB0);
        step();
        check("t4_ack_held", {24'd0, bus.ctrl_din}, 32'hB0);
        bus.ctrl_cs = 1'b0;
        bus.cs      = 1'b1;
        bus.wrn     = 1'b0;
        bus.din     = 8'hE4;
        step();
        bus.cs  = 1'b0;
        bus.wrn = 1'b1;
        check("t4_level_same", {29'd0, level}, 32'd4);
        check("t4_no_ovf", {31'd0, ovf}, 32'd0);
        step();
        read_byte(8'hB1, "t4_rd1");
        read_byte(8'hB2, "t4_rd2");
        read_byte(8'hB3, "t4_rd3");
        read_byte(8'hE4, "t4_rd_new");

        // 5: request waits on an empty FIFO
        bus.ctrl_cs = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("t5_wait_ok", {31'd0, bus.ctrl_ok}, 32'd0);
        bus.cs  = 1'b1;
        bus.wrn = 1'b0;
        bus.din = 8'h5C;
        step();
        bus.cs  = 1'b0;
        bus.wrn = 1'b1;
        check("t5_level1", {29'd0, level}, 32'd1);
        check("t5_ok_not_yet", {31'd0, bus.ctrl_ok}, 32'd0);
        step();
        check("t5_ok_rise", {31'd0, bus.ctrl_ok}, 32'd1);
        check("t5_din", {24'd0, bus.ctrl_din}, 32'h5C);
        bus.ctrl_cs = 1'b0;
        step();
        check("t5_popped", {29'd0, level}, 32'd0);
        check("t5_ok_drop", {31'd0, bus.ctrl_ok}, 32'd0);

        // 6: master mode, then reset mid-transfer
        for (int i = 0; i < 5; i++) host_write(8'hC0 + 8'(i));
        mdn           = 1'b1;
        bus.ctrl_cs   = 1'b1;
        bus.ctrl_addr = 17'h1ABCD;
        bus.rom_data  = 8'h7E;
        bus.rom_ok    = 1'b1;
        #1;
        check("t6_rom_cs", {31'd0, bus.rom_cs}, 32'd1);
        check("t6_rom_addr", {15'd0, bus.rom_addr}, 32'h1ABCD);
        check("t6_ctrl_din", {24'd0, bus.ctrl_din}, 32'h7E);
        check("t6_ctrl_ok", {31'd0, bus.ctrl_ok}, 32'd1);
        step();
        check("t6_discard", {29'd0, level}, 32'd0);
        check("t6_ovf_hold", {31'd0, ovf}, 32'd1);
        check("t6_drqn", {31'd0, bus.drqn}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_level", {29'd0, level}, 32'd0);
        check("t6_rst_ovf", {31'd0, ovf}, 32'd0);
        check("t6_rst_drqn", {31'd0, bus.drqn}, 32'd1);
        rst         = 1'b0;
        mdn         = 1'b0;
        bus.ctrl_cs = 1'b0;
        bus.rom_ok  = 1'b0;
        step();
        check("t6_slave_level", {29'd0, level}, 32'd0);
        check("t6_slave_ok", {31'd0, bus.ctrl_ok}, 32'd0);
        check("t6_slave_rom_cs", {31'd0, bus.rom_cs}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jt7759_fifo.md
Name: jt7759_fifo

Overview:
- Parametrised data-input stage for the jt7759 ADPCM core; sits between the control FSM's byte-fetch interface and either external ROM (master mode) or the host CPU write port (slave mode).
- Extends the single-byte slave buffer of the previous generation to a DEPTH-entry FIFO.
- Adds a programmable DRQ low-water mark, an occupancy output, a sticky overflow flag and a synchronous flush.
- Master mode remains a ROM pass-through.

Parameters:
DW, 8, data width of host bus, ROM data and FIFO entries.
AW, 17, ROM/control address width.
DEPTH, 4, FIFO entries; power of two, 2..16.
LOWMARK, 1, DRQ is requested while occupancy <= LOWMARK; valid range 0..DEPTH-1.
HOLDOFF, 3, cen4 ticks that drqn stays high after each accepted host write.

Ports:
rst  in  1  asynchronous reset, active high
clk  in  1  system clock
cen4  in  1  clock enable used for the DRQ hold-off count
mdn  in  1  1 = master (ROM) mode, 0 = slave (host FIFO) mode
flush  in  1  synchronous FIFO clear, active high
ctrl_cs  in  1  read request from control FSM, held high until ctrl_ok is seen
ctrl_addr  in  AW  byte address from control FSM
ctrl_din  out  DW  byte delivered to control FSM
ctrl_ok  out  1  ctrl_din valid for the current request
rom_cs  out  1  ROM request
rom_addr  out  AW  ROM address
rom_data  in  DW  ROM data
rom_ok  in  1  ROM data valid
cs  in  1  host chip select
wrn  in  1  host write strobe, active low
din  in  DW  host write data
drqn  out  1  data request to host, active low
level  out  $clog2(DEPTH+1)  current FIFO occupancy
ovf  out  1  sticky overflow flag

Behaviour:
- Reset (async, rst=1):
  - FIFO empty; read and write pointers cleared.
  - Outputs: level=0, ovf=0, drqn=1, ctrl_ok=0 in slave mode.
  - Write-edge detector register (last_wrn) set to 1; hold-off counter cleared to 0.
  - A read transaction in progress is abandoned.
- Master mode (mdn=1), combinational pass-through:
  - rom_cs=ctrl_cs, rom_addr=ctrl_addr, ctrl_din=rom_data, ctrl_ok=rom_ok.
  - FIFO forced empty every cycle.
  - drqn=1; ovf holds its value.
- Slave mode (mdn=0):
  - rom_cs=0; rom_addr=ctrl_addr in both modes.
- Push:
  - Accepted in a cycle where cs=1, wrn=0 and last_wrn=1 (falling-edge detect, one push per strobe).
  - If the FIFO is full and no pop happens in the same cycle, din is dropped and ovf is set.
  - ovf is cleared only by rst or flush.
- Read transaction states: IDLE, WAIT, ACK.
  - IDLE -> WAIT on a rising edge of ctrl_cs.
  - WAIT -> ACK in the first cycle with level>0. ctrl_ok goes 1 (registered) and ctrl_din is registered from the FIFO head.
  - ACK: ctrl_ok and ctrl_din are held while ctrl_cs=1.
  - ACK -> IDLE when ctrl_cs falls. The head is popped in that same cycle and ctrl_ok drops to 0.
  - WAIT -> IDLE when ctrl_cs falls before data was available; no pop.
  - A new rising edge of ctrl_cs is needed for the next byte.
- Pointer and occupancy arithmetic:
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Occupancy is tracked in a separate counter that updates the cycle after the event.
  - Push and pop in the same cycle: both performed, level unchanged, push never flagged as overflow even when full.
- drqn (slave mode):
  - drqn=0 when level<=LOWMARK, the hold-off counter is 0 and there is no push in the current cycle; otherwise drqn=1.
  - Each accepted push reloads the hold-off counter to HOLDOFF.
  - The counter decrements on cen4 while nonzero.
  - Dropped writes do not reload the counter.
- flush=1:
  - Empties the FIFO, clears ovf and returns the read FSM to IDLE with ctrl_ok=0.
  - Overrides a push in the same cycle.
  - Leaves the hold-off counter unchanged.
- mdn transitions:
  - 0->1: FIFO contents are discarded.
  - 1->0: starts with the FIFO empty and the read FSM in IDLE.

Test Plan:
1. Slave, DEPTH=4: write 0x11,0x22,0x33 with no reads -> level=3, ovf=0. Then three ctrl_cs handshakes -> ctrl_din 0x11,0x22,0x33 in order, level returns to 0.
2. Slave, DEPTH=4: write 0xA0..0xA4 (five writes) -> first four stored, level=4, ovf=1. Reads return 0xA0..0xA3; ovf stays 1 until flush pulse, then 0.
3. Slave, LOWMARK=1, HOLDOFF=3, cen4 every 4th clk: push one byte -> drqn=1 for 3 cen4 ticks, then 0 (level=1). Push second byte -> drqn stays 1 after hold-off (level=2).
4. Slave, FIFO full: pop and host write in the same clk -> level stays 4, ovf=0, new byte read out last.
5. ctrl_cs raised with FIFO empty, write 0x5C after 10 clks -> ctrl_ok rises the cycle after level=1, ctrl_din=0x5C. Dropping ctrl_cs pops: level=0.
6. Master mode: ctrl_cs=1, ctrl_addr=0x1ABCD, rom_data=0x7E, rom_ok=1 -> rom_cs=1, rom_addr=0x1ABCD, ctrl_din=0x7E, ctrl_ok=1, drqn=1. Asserting rst mid-transfer -> level=0, ovf=0, drqn=1.
